// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Shares one combinational ALU between two requesters. Each requester has
//   a valid/ready request port and a one-entry registered response slot.
//   At most one ALU operation is issued per cycle. Ties go round-robin, or
//   always to requester 0 when FIXED_PRIO is set.
//
// Ports
//   clk                      rising-edge clock for all state
//   rst_n                    synchronous, active-low reset
//   req{0,1}_valid/ready     request handshake (ready is combinational)
//   req{0,1}_op/_a/_b        request opcode and operands
//   rsp{0,1}_valid/ready     response slot handshake
//   rsp{0,1}_result          registered ALU result for that requester
//   alu_op/_a/_b             operation presented to the shared ALU
//   alu_result               combinational ALU result, captured into a slot
module alu_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned OP_WIDTH   = 4,
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [OP_WIDTH-1:0]   req0_op,
  input  logic [DATA_WIDTH-1:0] req0_a,
  input  logic [DATA_WIDTH-1:0] req0_b,
  output logic                  rsp0_valid,
  input  logic                  rsp0_ready,
  output logic [DATA_WIDTH-1:0] rsp0_result,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [OP_WIDTH-1:0]   req1_op,
  input  logic [DATA_WIDTH-1:0] req1_a,
  input  logic [DATA_WIDTH-1:0] req1_b,
  output logic                  rsp1_valid,
  input  logic                  rsp1_ready,
  output logic [DATA_WIDTH-1:0] rsp1_result,
  output logic [OP_WIDTH-1:0]   alu_op,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  input  logic [DATA_WIDTH-1:0] alu_result
);

  // Port-indexed views so per-port logic can be written once.
  logic [1:0]            req_valid;
  logic [1:0]            rsp_ready;
  logic [1:0]            rsp_valid;
  logic [1:0]            eligible;
  logic [1:0]            grant;
  logic [DATA_WIDTH-1:0] rsp_result [2];

  assign req_valid = {req1_valid, req0_valid};
  assign rsp_ready = {rsp1_ready, rsp0_ready};

  // Round-robin pointer: 0 means requester 0 wins the next tie.
  logic rr_q;
  logic rr_d;

  // Per-port response slot.
  for (genvar gi = 0; gi < 2; gi++) begin : g_slot
    logic                  valid_q;
    logic                  valid_d;
    logic [DATA_WIDTH-1:0] result_q;
    logic [DATA_WIDTH-1:0] result_d;

    // A port may take a new operation when its slot is empty or is being
    // consumed in this same cycle.
    assign eligible[gi] = req_valid[gi] && (!valid_q || rsp_ready[gi]);

    always_comb begin
      valid_d  = valid_q;
      result_d = result_q;
      if (grant[gi]) begin
        // A grant overrides a same-cycle drain: the slot is refilled.
        valid_d  = 1'b1;
        result_d = alu_result;
      end else if (valid_q && rsp_ready[gi]) begin
        valid_d  = 1'b0;
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        valid_q  <= 1'b0;
        result_q <= '0;
      end else begin
        valid_q  <= valid_d;
        result_q <= result_d;
      end
    end

    assign rsp_valid[gi]  = valid_q;
    assign rsp_result[gi] = result_q;
  end

  // Arbitration. Grants are suppressed while reset is asserted so no
  // requester believes an operation was accepted during reset.
  always_comb begin
    grant = 2'b00;
    if (rst_n) begin
      case (eligible)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11: begin
          if ((FIXED_PRIO != 0) || !rr_q) begin
            grant = 2'b01;
          end else begin
            grant = 2'b10;
          end
        end
        default: grant = 2'b00;
      endcase
    end
  end

  // Pointer moves to the port that did not just win; held at 0 when the
  // arbiter runs in fixed-priority mode.
  always_comb begin
    rr_d = rr_q;
    if (FIXED_PRIO != 0) begin
      rr_d = 1'b0;
    end else if (grant[0]) begin
      rr_d = 1'b1;
    end else if (grant[1]) begin
      rr_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_q <= 1'b0;
    end else begin
      rr_q <= rr_d;
    end
  end

  // Shared ALU drive: granted port's operation, zeros when idle.
  always_comb begin
    alu_op = '0;
    alu_a  = '0;
    alu_b  = '0;
    if (grant[0]) begin
      alu_op = req0_op;
      alu_a  = req0_a;
      alu_b  = req0_b;
    end else if (grant[1]) begin
      alu_op = req1_op;
      alu_a  = req1_a;
      alu_b  = req1_b;
    end
  end

  assign req0_ready  = grant[0];
  assign req1_ready  = grant[1];
  assign rsp0_valid  = rsp_valid[0];
  assign rsp1_valid  = rsp_valid[1];
  assign rsp0_result = rsp_result[0];
  assign rsp1_result = rsp_result[1];

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter
//   Drives a round-robin instance (d0) and a fixed-priority instance (d1)
//   with the same request stimulus. Each instance has its own ALU model.
//   A per-port scoreboard queues the expected result at every accepted
//   request and compares it when the response is consumed; directed checks
//   cover grant ordering, slot hold, drain/refill and reset behaviour.
module tb_alu_arbiter;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  rsp_ready;
  logic [3:0]  req_op [2];
  logic [31:0] req_a  [2];
  logic [31:0] req_b  [2];

  // index = dut*2 + port
  logic        mon_req_ready  [4];
  logic        mon_rsp_valid  [4];
  logic [31:0] mon_rsp_result [4];

  logic [3:0]  alu_op  [2];
  logic [31:0] alu_a   [2];
  logic [31:0] alu_b   [2];
  logic [31:0] alu_res [2];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_ref(input logic [3:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_XOR: return a ^ b;
      default: return 32'd0;
    endcase
  endfunction

  always_comb alu_res[0] = alu_ref(alu_op[0], alu_a[0], alu_b[0]);
  always_comb alu_res[1] = alu_ref(alu_op[1], alu_a[1], alu_b[1]);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  alu_arbiter #(.DATA_WIDTH(32), .OP_WIDTH(4), .FIXED_PRIO(0)) dut_rr (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req_valid[0]), .req0_ready(mon_req_ready[0]),
    .req0_op(req_op[0]), .req0_a(req_a[0]), .req0_b(req_b[0]),
    .rsp0_valid(mon_rsp_valid[0]), .rsp0_ready(rsp_ready[0]), .rsp0_result(mon_rsp_result[0]),
    .req1_valid(req_valid[1]), .req1_ready(mon_req_ready[1]),
    .req1_op(req_op[1]), .req1_a(req_a[1]), .req1_b(req_b[1]),
    .rsp1_valid(mon_rsp_valid[1]), .rsp1_ready(rsp_ready[1]), .rsp1_result(mon_rsp_result[1]),
    .alu_op(alu_op[0]), .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_result(alu_res[0])
  );

  alu_arbiter #(.DATA_WIDTH(32), .OP_WIDTH(4), .FIXED_PRIO(1)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req_valid[0]), .req0_ready(mon_req_ready[2]),
    .req0_op(req_op[0]), .req0_a(req_a[0]), .req0_b(req_b[0]),
    .rsp0_valid(mon_rsp_valid[2]), .rsp0_ready(rsp_ready[0]), .rsp0_result(mon_rsp_result[2]),
    .req1_valid(req_valid[1]), .req1_ready(mon_req_ready[3]),
    .req1_op(req_op[1]), .req1_a(req_a[1]), .req1_b(req_b[1]),
    .rsp1_valid(mon_rsp_valid[3]), .rsp1_ready(rsp_ready[1]), .rsp1_result(mon_rsp_result[3]),
    .alu_op(alu_op[1]), .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_result(alu_res[1])
  );

  // Scoreboard per (dut, port), sampled on the falling edge.
  for (genvar gi = 0; gi < 4; gi++) begin : g_mon
    logic [31:0] sbq [$];
    logic [31:0] exp_v;
    always @(negedge clk) begin
      if (!rst_n) begin
        check($sformatf("d%0d.req%0d_ready_in_reset", gi / 2, gi % 2),
              32'(mon_req_ready[gi]), 32'd0);
        sbq.delete();
      end else begin
        check($sformatf("d%0d.rsp%0d_occupancy", gi / 2, gi % 2),
              32'(mon_rsp_valid[gi]), 32'(sbq.size() != 0));
        if (mon_rsp_valid[gi] && rsp_ready[gi % 2] && (sbq.size() != 0)) begin
          exp_v = sbq.pop_front();
          check($sformatf("d%0d.rsp%0d_result", gi / 2, gi % 2), mon_rsp_result[gi], exp_v);
          $display("[%0t] d%0d rsp%0d result=0x%08h expected=0x%08h",
                   $time, gi / 2, gi % 2, mon_rsp_result[gi], exp_v);
        end
        if (mon_req_ready[gi]) begin
          sbq.push_back(alu_ref(req_op[gi % 2], req_a[gi % 2], req_b[gi % 2]));
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic set_req(input int p, input logic v, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b);
    req_valid[p] = v;
    req_op[p]    = op;
    req_a[p]     = a;
    req_b[p]     = b;
  endtask

  task automatic idle();
    set_req(0, 1'b0, 4'd0, 32'd0, 32'd0);
    set_req(1, 1'b0, 4'd0, 32'd0, 32'd0);
  endtask

  task automatic rand_req(input int p);
    set_req(p, 1'b1, 4'($urandom_range(0, 4)), $urandom, $urandom);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n     = 1'b0;
    rsp_ready = 2'b11;
    idle();
    next_cycle();
    next_cycle();
    rst_n = 1'b1;

    // Reset state and idle ALU drive
    sample();
    check("reset_rsp0_valid",  32'(mon_rsp_valid[0]), 32'd0);
    check("reset_rsp0_result", mon_rsp_result[0], 32'd0);
    check("reset_rsp1_valid",  32'(mon_rsp_valid[1]), 32'd0);
    check("idle_alu_op", 32'(alu_op[0]), 32'd0);
    check("idle_alu_a",  alu_a[0], 32'd0);
    next_cycle();

    // 1: single ADD, same-cycle ready, result next cycle
    set_req(0, 1'b1, ALU_ADD, 32'd5, 32'd7);
    sample();
    check("t1_req0_ready", 32'(mon_req_ready[0]), 32'd1);
    check("t1_alu_op", 32'(alu_op[0]), 32'(ALU_ADD));
    check("t1_alu_a",  alu_a[0], 32'd5);
    check("t1_alu_b",  alu_b[0], 32'd7);
    next_cycle();
    idle();
    sample();
    check("t1_rsp0_valid",  32'(mon_rsp_valid[0]), 32'd1);
    check("t1_rsp0_result", mon_rsp_result[0], 32'd12);
    next_cycle();

    // Lone req1 grant so the pointer prefers req0 at the next tie
    set_req(1, 1'b1, ALU_ADD, 32'd1, 32'd1);
    sample();
    check("prep_req1_ready", 32'(mon_req_ready[1]), 32'd1);
    next_cycle();

    // 2: both valid every cycle -> alternating grants on d0, req0 always on d1
    for (int k = 0; k < 4; k++) begin
      rand_req(0);
      set_req(1, 1'b1, ALU_SUB, 32'd3, 32'd5);
      sample();
      check($sformatf("t2_rr_req0_ready_%0d", k), 32'(mon_req_ready[0]), 32'((k % 2) == 0));
      check($sformatf("t2_rr_req1_ready_%0d", k), 32'(mon_req_ready[1]), 32'((k % 2) == 1));
      check($sformatf("t2_fp_req0_ready_%0d", k), 32'(mon_req_ready[2]), 32'd1);
      check($sformatf("t2_fp_req1_ready_%0d", k), 32'(mon_req_ready[3]), 32'd0);
      if (k == 2) begin
        check("t2_rsp1_valid",  32'(mon_rsp_valid[1]), 32'd1);
        check("t2_rsp1_result", mon_rsp_result[1], 32'hFFFF_FFFE);
      end
      next_cycle();
    end

    // 3: slot 0 full and stalled -> req1 wins every cycle, result held
    idle();
    set_req(0, 1'b1, ALU_ADD, 32'd100, 32'd23);
    sample();
    next_cycle();
    rsp_ready = 2'b10;
    for (int k = 0; k < 3; k++) begin
      rand_req(0);
      rand_req(1);
      sample();
      check($sformatf("t3_req0_ready_%0d", k),  32'(mon_req_ready[0]), 32'd0);
      check($sformatf("t3_req1_ready_%0d", k),  32'(mon_req_ready[1]), 32'd1);
      check($sformatf("t3_fp_req1_ready_%0d", k), 32'(mon_req_ready[3]), 32'd1);
      check($sformatf("t3_rsp0_valid_%0d", k),  32'(mon_rsp_valid[0]), 32'd1);
      check($sformatf("t3_rsp0_result_%0d", k), mon_rsp_result[0], 32'd123);
      next_cycle();
    end

    // 4: drain and refill slot 0 in the same cycle
    rsp_ready = 2'b11;
    idle();
    set_req(0, 1'b1, ALU_XOR, 32'h0000_00F0, 32'h0000_00FF);
    sample();
    check("t4_req0_ready", 32'(mon_req_ready[0]), 32'd1);
    next_cycle();
    idle();
    sample();
    check("t4_rsp0_valid",  32'(mon_rsp_valid[0]), 32'd1);
    check("t4_rsp0_result", mon_rsp_result[0], 32'h0000_000F);
    next_cycle();

    // 5: reset while slot 0 holds a result; pointer returns to req0
    rsp_ready = 2'b10;
    set_req(0, 1'b1, ALU_ADD, 32'd2, 32'd2);
    sample();
    check("t5_pre_req0_ready", 32'(mon_req_ready[0]), 32'd1);
    next_cycle();
    rst_n = 1'b0;
    rand_req(0);
    rand_req(1);
    sample();
    check("t5_rsp0_valid_before", 32'(mon_rsp_valid[0]), 32'd1);
    check("t5_req1_ready_in_rst", 32'(mon_req_ready[1]), 32'd0);
    next_cycle();
    rst_n     = 1'b1;
    rsp_ready = 2'b11;
    rand_req(0);
    rand_req(1);
    sample();
    check("t5_rsp0_valid_after",  32'(mon_rsp_valid[0]), 32'd0);
    check("t5_rsp0_result_after", mon_rsp_result[0], 32'd0);
    check("t5_rsp1_valid_after",  32'(mon_rsp_valid[1]), 32'd0);
    check("t5_tie_req0_ready",    32'(mon_req_ready[0]), 32'd1);
    check("t5_tie_req1_ready",    32'(mon_req_ready[1]), 32'd0);
    next_cycle();

    // 6: fixed priority keeps granting req0 until it drops
    for (int k = 0; k < 4; k++) begin
      rand_req(0);
      rand_req(1);
      sample();
      check($sformatf("t6_fp_req0_ready_%0d", k), 32'(mon_req_ready[2]), 32'd1);
      check($sformatf("t6_fp_req1_ready_%0d", k), 32'(mon_req_ready[3]), 32'd0);
      next_cycle();
    end
    req_valid[0] = 1'b0;
    rand_req(1);
    sample();
    check("t6_fp_req1_ready_alone", 32'(mon_req_ready[3]), 32'd1);
    next_cycle();

    // Drain outstanding responses
    idle();
    for (int k = 0; k < 3; k++) begin
      sample();
      next_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
